// File: rtl/ctrl_interrup.sv
// Vectored interrupt controller: rising-edge request capture, fixed-priority
// selection, one-cycle return-address push and vector steer, RETI handshake.
module ctrl_interrup #(
    parameter int unsigned     NIRQ  = 4,
    parameter int unsigned     PCW   = 10,
    parameter logic [PCW-1:0]  VBASE = 10'h3F0,
    parameter int unsigned     VSTEP = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NIRQ-1:0]      irq,
    input  logic                 mask_we,
    input  logic [NIRQ-1:0]      mask_wd,
    input  logic                 ie_set,
    input  logic                 ie_clr,
    input  logic                 reti,
    input  logic [PCW-1:0]       pc_actual,
    output logic                 push,
    output logic [PCW-1:0]       inpush,
    output logic                 s_vec,
    output logic [PCW-1:0]       pc_vec,
    output logic                 en_servicio,
    output logic [((NIRQ > 1) ? $clog2(NIRQ) : 1)-1:0] irq_id,
    output logic [NIRQ-1:0]      mask_q,
    output logic                 ie_q
);

    localparam int unsigned IDW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        GUARDA   = 2'd1,
        SERVICIO = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [NIRQ-1:0]   pending_q, pending_d;
    logic [NIRQ-1:0]   irq_prev_q, irq_prev_d;
    logic [NIRQ-1:0]   mask_d;
    logic              ie_d;
    logic [IDW-1:0]    irq_id_q, irq_id_d;

    logic [NIRQ-1:0]   req_c;
    logic [IDW-1:0]    sel_id_c;
    logic [NIRQ-1:0]   clr_c;
    logic              in_guarda_c;

    // Fixed priority: lowest enabled pending index wins
    always_comb begin
        req_c    = pending_q & mask_q;
        sel_id_c = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req_c[i]) begin
                sel_id_c = IDW'(i);
            end
        end
    end

    // Next state, pending capture/clear, mask and global enable updates
    always_comb begin
        state_d    = state_q;
        irq_id_d   = irq_id_q;
        clr_c      = '0;
        irq_prev_d = irq;
        mask_d     = mask_we ? mask_wd : mask_q;
        ie_d       = ie_q;

        case (state_q)
            REPOSO: begin
                if (ie_q && (|req_c)) begin
                    state_d  = GUARDA;
                    irq_id_d = sel_id_c;
                end
            end
            GUARDA: begin
                clr_c   = NIRQ'(1) << irq_id_q;
                state_d = SERVICIO;
            end
            SERVICIO: begin
                if (reti) begin
                    state_d = REPOSO;
                end
            end
            default: begin
                state_d = REPOSO;
            end
        endcase

        // A fresh edge in the clearing cycle keeps the line pending
        pending_d = (pending_q & ~clr_c) | (irq & ~irq_prev_q);

        // DI beats EI and RETI; entering service always disables
        if (state_q == GUARDA) begin
            ie_d = 1'b0;
        end else if (ie_clr) begin
            ie_d = 1'b0;
        end else if (ie_set || (state_q == SERVICIO && reti)) begin
            ie_d = 1'b1;
        end
    end

    // State and control registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= REPOSO;
            pending_q  <= '0;
            irq_prev_q <= '0;
            mask_q     <= '0;
            ie_q       <= 1'b0;
            irq_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            irq_prev_q <= irq_prev_d;
            mask_q     <= mask_d;
            ie_q       <= ie_d;
            irq_id_q   <= irq_id_d;
        end
    end

    // Stack/PC controls decoded straight from the state flop so they can only
    // be high during the single GUARDA cycle
    always_comb begin
        in_guarda_c = (state_q == GUARDA);
        push        = in_guarda_c;
        s_vec       = in_guarda_c;
        inpush      = in_guarda_c ? pc_actual : '0;
        pc_vec      = in_guarda_c ? (VBASE + PCW'(irq_id_q) * PCW'(VSTEP)) : '0;
        en_servicio = (state_q == SERVICIO);
        irq_id      = irq_id_q;
    end

endmodule

// File: tb/tb_ctrl_interrup.sv
// Self-checking bench for ctrl_interrup with a push scoreboard.
`timescale 1ns/1ps
module tb_ctrl_interrup;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq;
    logic        mask_we;
    logic [3:0]  mask_wd;
    logic        ie_set;
    logic        ie_clr;
    logic        reti;
    logic [9:0]  pc_actual;
    logic        push;
    logic [9:0]  inpush;
    logic        s_vec;
    logic [9:0]  pc_vec;
    logic        en_servicio;
    logic [1:0]  irq_id;
    logic [3:0]  mask_q;
    logic        ie_q;

    int n_pass  = 0;
    int n_total = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [9:0] pc;
        logic [9:0] vec;
        logic [1:0] id;
    } exp_t;
    exp_t exp_q[$];

    ctrl_interrup dut (
        .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_wd(mask_wd),
        .ie_set(ie_set), .ie_clr(ie_clr), .reti(reti), .pc_actual(pc_actual),
        .push(push), .inpush(inpush), .s_vec(s_vec), .pc_vec(pc_vec),
        .en_servicio(en_servicio), .irq_id(irq_id), .mask_q(mask_q), .ie_q(ie_q)
    );

    always #5 clk = ~clk;

    // Scoreboard: every push must match the oldest expectation; s_vec tracks push
    always @(negedge clk) begin
        if (mon_en) begin
            if (push === 1'b1) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected_push got inpush=%h pc_vec=%h id=%0d exp=no push",
                             inpush, pc_vec, irq_id);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({inpush, pc_vec, irq_id, s_vec} !== {e.pc, e.vec, e.id, 1'b1})
                        $display("FAIL sb_push got inpush=%h pc_vec=%h id=%0d s_vec=%b exp inpush=%h pc_vec=%h id=%0d s_vec=1",
                                 inpush, pc_vec, irq_id, s_vec, e.pc, e.vec, e.id);
                    else
                        n_pass++;
                end
            end else if (s_vec !== 1'b0 || push !== 1'b0) begin
                n_total++;
                $display("FAIL sb_idle_ctrl got push=%b s_vec=%b exp push=0 s_vec=0", push, s_vec);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input logic [9:0] pc, input logic [9:0] vec, input logic [1:0] id);
        exp_t e;
        e.pc = pc; e.vec = vec; e.id = id;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b0; irq = 4'b1111; pc_actual = 10'h155;
        tick();
        irq = 4'b0000;
        tick();
        mon_en = 1'b1;
        n_total++;
        if ({push, s_vec, en_servicio, mask_q, ie_q, irq_id, inpush, pc_vec} !== 27'd0)
            $display("FAIL reset_outputs got push=%b s_vec=%b en=%b mask=%b ie=%b id=%0d inpush=%h pc_vec=%h exp all 0",
                     push, s_vec, en_servicio, mask_q, ie_q, irq_id, inpush, pc_vec);
        else n_pass++;
        reset = 1'b1;
        // Enabled, pending request but no EI: must not be served
        mask_we = 1'b1; mask_wd = 4'b1111;
        tick();
        mask_we = 1'b0; irq = 4'b0010;
        tick();
        irq = 4'b0000;
        repeat (5) tick();
        n_total++;
        if (en_servicio !== 1'b0 || ie_q !== 1'b0)
            $display("FAIL reset_no_ei got en=%b ie=%b exp en=0 ie=0", en_servicio, ie_q);
        else n_pass++;
        // Clear the stale pending before the next scenario
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        pc_actual = 10'h025;
        mask_we = 1'b1; mask_wd = 4'b0100; ie_set = 1'b1;
        tick();
        mask_we = 1'b0; ie_set = 1'b0;
        n_total++;
        if (ie_q !== 1'b1 || mask_q !== 4'b0100)
            $display("FAIL basic_setup got ie=%b mask=%b exp ie=1 mask=0100", ie_q, mask_q);
        else n_pass++;
        irq = 4'b0100;
        expect_push(10'h025, 10'h3F8, 2'd2);
        tick();                                   // edge k
        n_total++;
        if (push !== 1'b0) $display("FAIL basic_k got push=%b exp=0", push);
        else n_pass++;
        tick();                                   // edge k+1
        n_total++;
        if (push !== 1'b1 || irq_id !== 2'd2)
            $display("FAIL basic_guarda got push=%b id=%0d exp push=1 id=2", push, irq_id);
        else n_pass++;
        tick();                                   // edge k+2
        n_total++;
        if (push !== 1'b0 || en_servicio !== 1'b1 || ie_q !== 1'b0)
            $display("FAIL basic_servicio got push=%b en=%b ie=%b exp push=0 en=1 ie=0",
                     push, en_servicio, ie_q);
        else n_pass++;
        irq = 4'b0000;
        repeat (3) tick();
        reti = 1'b1;
        tick();
        reti = 1'b0;
        n_total++;
        if (en_servicio !== 1'b0 || ie_q !== 1'b1)
            $display("FAIL basic_reti got en=%b ie=%b exp en=0 ie=1", en_servicio, ie_q);
        else n_pass++;
        tick();
    endtask

    task automatic test_priority();
        pc_actual = 10'h1A3;
        mask_we = 1'b1; mask_wd = 4'b1111;
        tick();
        mask_we = 1'b0;
        irq = 4'b1010;
        expect_push(10'h1A3, 10'h3F4, 2'd1);
        expect_push(10'h1A3, 10'h3FC, 2'd3);
        tick();
        tick();
        n_total++;
        if (push !== 1'b1 || irq_id !== 2'd1)
            $display("FAIL prio_first got push=%b id=%0d exp push=1 id=1", push, irq_id);
        else n_pass++;
        tick();
        irq = 4'b0000;
        repeat (2) tick();
        reti = 1'b1;
        tick();
        reti = 1'b0;
        n_total++;
        if (en_servicio !== 1'b0 || push !== 1'b0 || ie_q !== 1'b1)
            $display("FAIL prio_reposo got en=%b push=%b ie=%b exp en=0 push=0 ie=1",
                     en_servicio, push, ie_q);
        else n_pass++;
        tick();
        n_total++;
        if (push !== 1'b1 || irq_id !== 2'd3)
            $display("FAIL prio_second got push=%b id=%0d exp push=1 id=3", push, irq_id);
        else n_pass++;
        tick();
        reti = 1'b1;
        tick();
        reti = 1'b0;
        tick();
    endtask

    task automatic test_mask();
        int seen;
        pc_actual = 10'h2C0;
        mask_we = 1'b1; mask_wd = 4'b0000;
        tick();
        mask_we = 1'b0;
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (push !== 1'b0 || en_servicio !== 1'b0) seen++;
        end
        n_total++;
        if (seen != 0 || ie_q !== 1'b1)
            $display("FAIL mask_hold got active_cycles=%0d ie=%b exp active_cycles=0 ie=1", seen, ie_q);
        else n_pass++;
        mask_we = 1'b1; mask_wd = 4'b0001;
        expect_push(10'h2C0, 10'h3F0, 2'd0);
        tick();                                   // write edge: old mask decided
        mask_we = 1'b0;
        n_total++;
        if (push !== 1'b0 || mask_q !== 4'b0001)
            $display("FAIL mask_write got push=%b mask=%b exp push=0 mask=0001", push, mask_q);
        else n_pass++;
        tick();
        n_total++;
        if (push !== 1'b1 || pc_vec !== 10'h3F0)
            $display("FAIL mask_guarda got push=%b pc_vec=%h exp push=1 pc_vec=3f0", push, pc_vec);
        else n_pass++;
        tick();
        reti = 1'b1;
        tick();
        reti = 1'b0;
        tick();
    endtask

    task automatic test_held_level();
        pc_actual = 10'h0F1;
        mask_we = 1'b1; mask_wd = 4'b0100;
        tick();
        mask_we = 1'b0;
        irq = 4'b0100;
        expect_push(10'h0F1, 10'h3F8, 2'd2);
        tick();
        tick();
        n_total++;
        if (push !== 1'b1) $display("FAIL held_guarda got push=%b exp=1", push);
        else n_pass++;
        repeat (4) tick();
        reti = 1'b1;
        tick();
        reti = 1'b0;
        repeat (5) tick();
        n_total++;
        if (en_servicio !== 1'b0 || exp_q.size() != 0)
            $display("FAIL held_single got en=%b outstanding=%0d exp en=0 outstanding=0",
                     en_servicio, exp_q.size());
        else n_pass++;
        irq = 4'b0000;
        ie_set = 1'b1; ie_clr = 1'b1;
        tick();
        ie_set = 1'b0; ie_clr = 1'b0;
        n_total++;
        if (ie_q !== 1'b0) $display("FAIL ie_set_clr got ie=%b exp=0", ie_q);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_in_service();
        pc_actual = 10'h333;
        ie_set = 1'b1;
        tick();
        ie_set = 1'b0;
        irq = 4'b0100;
        expect_push(10'h333, 10'h3F8, 2'd2);
        tick();
        tick();
        tick();
        irq = 4'b0000;
        n_total++;
        if (en_servicio !== 1'b1) $display("FAIL rst_svc_enter got en=%b exp=1", en_servicio);
        else n_pass++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        reti = 1'b1;
        tick();
        reti = 1'b0;
        n_total++;
        if (en_servicio !== 1'b0 || ie_q !== 1'b0 || push !== 1'b0 || mask_q !== 4'b0000)
            $display("FAIL rst_svc_reti got en=%b ie=%b push=%b mask=%b exp en=0 ie=0 push=0 mask=0000",
                     en_servicio, ie_q, push, mask_q);
        else n_pass++;
        repeat (4) tick();
        n_total++;
        if (exp_q.size() != 0 || ie_q !== 1'b0)
            $display("FAIL final_queue got outstanding=%0d ie=%b exp outstanding=0 ie=0",
                     exp_q.size(), ie_q);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b0; irq = '0; mask_we = 1'b0; mask_wd = '0;
        ie_set = 1'b0; ie_clr = 1'b0; reti = 1'b0; pc_actual = '0;
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_held_level();
        test_reset_in_service();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
